// File: rtl/wb8_interconnect.sv
// Pipelined 8-bit Wishbone interconnect: round-robin bus ownership per CYC,
// address-field slave decode and a no-ACK bus-error timeout.

module wb8_ic_mport (
  input  logic granted,
  input  logic reset,
  input  logic s_ack,
  input  logic s_stall,
  input  logic err_q,
  output logic m_ack,
  output logic m_stall,
  output logic m_err
);
  assign m_ack   = granted & ~reset & s_ack;
  assign m_stall = ~granted | reset | s_stall;
  assign m_err   = granted & ~reset & err_q;
endmodule

module wb8_interconnect #(
  parameter int MASTERS = 2,
  parameter int SLAVES  = 4,
  parameter int SEL_HI  = 31,
  parameter int SEL_LO  = 28,
  parameter logic [SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_BASES = {4'hF, 4'hE, 4'hD, 4'h0},
  parameter int TIMEOUT = 255
) (
  input  logic                  I_wb_clk,
  input  logic                  I_reset,
  input  logic [MASTERS-1:0]    I_m_cyc,
  input  logic [MASTERS-1:0]    I_m_stb,
  input  logic [MASTERS-1:0]    I_m_we,
  input  logic [32*MASTERS-1:0] I_m_adr,
  input  logic [8*MASTERS-1:0]  I_m_dat,
  output logic [7:0]            O_m_dat,
  output logic [MASTERS-1:0]    O_m_ack,
  output logic [MASTERS-1:0]    O_m_stall,
  output logic [MASTERS-1:0]    O_m_err,
  output logic [MASTERS-1:0]    O_grant,
  output logic [SLAVES-1:0]     O_s_stb,
  output logic                  O_s_we,
  output logic [31:0]           O_s_adr,
  output logic [7:0]            O_s_dat,
  input  logic [8*SLAVES-1:0]   I_s_dat,
  input  logic [SLAVES-1:0]     I_s_ack,
  input  logic [SLAVES-1:0]     I_s_stall
);
  localparam int W  = SEL_HI - SEL_LO + 1;
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  logic [MASTERS-1:0][31:0] m_adr;
  logic [MASTERS-1:0][7:0]  m_dat;
  logic [SLAVES-1:0][7:0]   s_dat;
  logic [SLAVES-1:0][W-1:0] bases;

  state_t             state;
  logic [MASTERS-1:0] grant;
  logic [MW-1:0]      owner, last, next_owner, cand;
  logic [CW-1:0]      ctr;
  logic               err_q;
  logic [SW-1:0]      sel;
  logic [31:0]        own_adr;
  logic               owned, own_cyc, own_stb, s_ack_sel, s_stall_sel;

  assign m_adr = I_m_adr;
  assign m_dat = I_m_dat;
  assign s_dat = I_s_dat;
  assign bases = SLAVE_BASES;

  // owner stays 0 while idle, so the slave-side mux shows master 0
  assign owned       = (state == S_OWNED);
  assign own_adr     = m_adr[owner];
  assign own_cyc     = I_m_cyc[owner];
  assign own_stb     = I_m_stb[owner];
  assign s_ack_sel   = I_s_ack[sel];
  assign s_stall_sel = I_s_stall[sel];

  // first matching base wins; unmatched addresses fall through to slave 0
  always_comb begin
    sel = '0;
    for (int i = SLAVES - 1; i >= 0; i--)
      if (own_adr[SEL_HI:SEL_LO] == bases[SW'(i)]) sel = SW'(i);
  end

  // round-robin: lowest k wins, searching from last owner + 1
  always_comb begin
    next_owner = '0;
    cand       = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      cand = MW'((int'(last) + k) % MASTERS);
      if (I_m_cyc[cand]) next_owner = cand;
    end
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state <= S_IDLE;
      grant <= '0;
      owner <= '0;
      last  <= MW'(MASTERS - 1);
      ctr   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          ctr <= '0;
          if (|I_m_cyc) begin
            state <= S_OWNED;
            owner <= next_owner;
            grant <= MASTERS'(1) << next_owner;
          end
        end
        S_OWNED: begin
          if (!own_cyc) begin
            state <= S_IDLE;
            grant <= '0;
            last  <= owner;
            owner <= '0;
            ctr   <= '0;
          end else if (TIMEOUT == 0 || s_ack_sel) begin
            ctr <= '0;
          end else if (ctr == TO_LAST) begin
            ctr   <= '0;
            err_q <= 1'b1;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    O_s_stb = '0;
    if (owned && own_stb && !err_q && !I_reset) O_s_stb[sel] = 1'b1;
  end

  assign O_grant = grant;
  assign O_s_we  = I_m_we[owner];
  assign O_s_adr = own_adr;
  assign O_s_dat = m_dat[owner];
  assign O_m_dat = s_dat[sel];

  wb8_ic_mport u_mport [MASTERS-1:0] (
    .granted (grant),
    .reset   (I_reset),
    .s_ack   (s_ack_sel),
    .s_stall (s_stall_sel),
    .err_q   (err_q),
    .m_ack   (O_m_ack),
    .m_stall (O_m_stall),
    .m_err   (O_m_err)
  );
endmodule

// File: tb/tb_wb8_interconnect.sv
// Randomized bench for wb8_interconnect against a cycle-counting ownership model.

module tb_wb8_interconnect;
  localparam int M  = 2;
  localparam int S  = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [M-1:0]         m_cyc, m_stb, m_we;
  logic [M-1:0][31:0]   m_adr;
  logic [M-1:0][7:0]    m_dat;
  logic [7:0]           o_m_dat;
  logic [M-1:0]         o_ack, o_stall, o_err, o_grant;
  logic [S-1:0]         o_s_stb;
  logic                 o_s_we;
  logic [31:0]          o_s_adr;
  logic [7:0]           o_s_dat;
  logic [S-1:0][7:0]    s_dat;
  logic [S-1:0]         s_ack, s_stall;

  wb8_interconnect #(.MASTERS(M), .SLAVES(S), .TIMEOUT(TO)) dut (
    .I_wb_clk (clk),     .I_reset  (rst),
    .I_m_cyc  (m_cyc),   .I_m_stb  (m_stb),  .I_m_we (m_we),
    .I_m_adr  (m_adr),   .I_m_dat  (m_dat),
    .O_m_dat  (o_m_dat), .O_m_ack  (o_ack),  .O_m_stall (o_stall),
    .O_m_err  (o_err),   .O_grant  (o_grant),
    .O_s_stb  (o_s_stb), .O_s_we   (o_s_we), .O_s_adr (o_s_adr), .O_s_dat (o_s_dat),
    .I_s_dat  (s_dat),   .I_s_ack  (s_ack),  .I_s_stall (s_stall)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Model: owner index (-1 idle), last owner, and the cycle number from which
  // the silent-slave interval is counted; err fires TO cycles after it.
  int  own_m  = -1;
  int  last_m = M - 1;
  int  quiet  = 0;
  int  cyc_n  = 0;
  bit  err_m  = 1'b0;
  bit  drop_req [M];
  logic [3:0] nibs [5] = '{4'h0, 4'hD, 4'hE, 4'hF, 4'h5};

  function automatic int dec(input logic [31:0] a);
    int base [S] = '{'h0, 'hD, 'hE, 'hF};
    int r = 0;
    for (int i = S - 1; i >= 0; i--) if (int'(a[31:28]) == base[i]) r = i;
    return r;
  endfunction

  task automatic drive(input int pack, input int pdrop);
    rst = ($urandom_range(99) < 2);
    for (int i = 0; i < M; i++) begin
      if (m_cyc[i]) m_cyc[i] = !(drop_req[i] || ($urandom_range(99) < pdrop));
      else          m_cyc[i] = ($urandom_range(99) < 30);
      drop_req[i] = 1'b0;
      m_stb[i] = m_cyc[i] && ($urandom_range(99) < 70);
      m_we[i]  = 1'($urandom);
      m_adr[i] = {nibs[$urandom_range(4)], 28'($urandom)};
      m_dat[i] = 8'($urandom);
    end
    for (int j = 0; j < S; j++) begin
      s_ack[j]   = ($urandom_range(99) < pack);
      s_stall[j] = ($urandom_range(99) < 30);
      s_dat[j]   = 8'($urandom);
    end
  endtask

  task automatic check_outputs();
    int own, sel;
    bit act;
    logic [M-1:0] e_ack, e_stall, e_err, e_grant;
    logic [S-1:0] e_stb;
    own = (own_m < 0) ? 0 : own_m;
    sel = dec(m_adr[own]);
    act = (own_m >= 0) && !rst;
    e_stb   = (act && m_stb[own] && !err_m) ? S'(1 << sel) : '0;
    e_grant = (own_m >= 0) ? M'(1 << own_m) : '0;
    e_ack   = '0;
    e_err   = '0;
    e_stall = '1;
    if (act) begin
      e_ack[own]   = s_ack[sel];
      e_stall[own] = s_stall[sel];
      e_err[own]   = err_m;
    end
    chk("grant", 32'(o_grant), 32'(e_grant));
    chk("s_stb", 32'(o_s_stb), 32'(e_stb));
    chk("s_we",  32'(o_s_we),  32'(m_we[own]));
    chk("s_adr", o_s_adr,      m_adr[own]);
    chk("s_dat", 32'(o_s_dat), 32'(m_dat[own]));
    chk("m_dat", 32'(o_m_dat), 32'(s_dat[sel]));
    chk("m_ack", 32'(o_ack),   32'(e_ack));
    chk("stall", 32'(o_stall), 32'(e_stall));
    chk("m_err", 32'(o_err),   32'(e_err));
    for (int i = 0; i < M; i++) if (e_err[i]) drop_req[i] = 1'b1;
  endtask

  task automatic advance();
    int nxt = 0;
    cyc_n++;
    if (rst) begin
      own_m = -1; last_m = M - 1; err_m = 1'b0;
    end else if (own_m < 0) begin
      err_m = 1'b0;
      if (|m_cyc) begin
        for (int k = M; k >= 1; k--) if (m_cyc[(last_m + k) % M]) nxt = (last_m + k) % M;
        own_m = nxt;
        quiet = cyc_n;
      end
    end else if (!m_cyc[own_m]) begin
      last_m = own_m; own_m = -1; err_m = 1'b0;
    end else if (s_ack[dec(m_adr[own_m])]) begin
      quiet = cyc_n; err_m = 1'b0;
    end else if (cyc_n - quiet == TO) begin
      err_m = 1'b1; quiet = cyc_n;
    end else begin
      err_m = 1'b0;
    end
  endtask

  task automatic run(input int n, input int pack, input int pdrop);
    for (int c = 0; c < n; c++) begin
      drive(pack, pdrop);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      advance();
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    s_dat = '0; s_ack = '0; s_stall = '0;
    for (int i = 0; i < M; i++) drop_req[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    advance();
    #1;
    run(600, 40, 15);
    run(400, 10, 10);
    run(500, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
